// File: rtl/layer_sequencer.sv
// layer_sequencer: steps one shared MAC/activation datapath over every neuron of a fully connected layer.
module layer_sequencer #(
   parameter int NUM_NEURONS = 4,
   parameter int NUM_INPUTS  = 8,
   parameter int XAW         = $clog2(NUM_INPUTS),
   parameter int WAW         = $clog2(NUM_NEURONS*NUM_INPUTS),
   parameter int OAW         = $clog2(NUM_NEURONS)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic           abort,
   input  logic           mem_ready,
   output logic           busy,
   output logic           done,
   output logic           clr_acc,
   output logic           en_mac,
   output logic           en_act,
   output logic           wr_out,
   output logic [XAW-1:0] x_addr,
   output logic [WAW-1:0] w_addr,
   output logic [OAW-1:0] out_addr
);
   typedef enum logic [2:0] {IDLE, CLEAR, MAC, ACT, WRITE, DONE} state_t;
   localparam logic [XAW-1:0] I_LAST = XAW'(NUM_INPUTS-1);
   localparam logic [OAW-1:0] N_LAST = OAW'(NUM_NEURONS-1);
   state_t state, state_nxt;
   logic [XAW-1:0] i, i_nxt;
   logic [OAW-1:0] n, n_nxt;
   logic [WAW-1:0] w, w_nxt;
   assign x_addr   = i;
   assign w_addr   = w;
   assign out_addr = n;
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         i     <= '0;
         n     <= '0;
         w     <= '0;
      end else begin
         state <= state_nxt;
         i     <= i_nxt;
         n     <= n_nxt;
         w     <= w_nxt;
      end
   end
   always_comb begin
      state_nxt = IDLE;
      i_nxt     = i;
      n_nxt     = n;
      w_nxt     = w;
      busy      = state != IDLE;
      clr_acc   = state == CLEAR;
      en_act    = state == ACT;
      wr_out    = state == WRITE;
      done      = state == DONE;
      en_mac    = 1'b0;
      case (state)
         IDLE: begin
            state_nxt = start ? CLEAR : IDLE;
            i_nxt     = '0;
            n_nxt     = '0;
            w_nxt     = '0;
         end
         CLEAR: state_nxt = MAC;
         MAC: begin
            en_mac    = mem_ready;
            state_nxt = (mem_ready && i == I_LAST) ? ACT : MAC;
            i_nxt     = mem_ready ? ((i == I_LAST) ? '0 : i + XAW'(1)) : i;
            w_nxt     = mem_ready ? w + WAW'(1) : w;
         end
         ACT: state_nxt = WRITE;
         WRITE: begin
            state_nxt = (n == N_LAST) ? DONE : CLEAR;
            n_nxt     = (n == N_LAST) ? n : n + OAW'(1);
         end
         DONE: begin
            n_nxt = '0;
            w_nxt = '0;
         end
         default: begin
            i_nxt = '0;
            n_nxt = '0;
            w_nxt = '0;
         end
      endcase
      // abort wins over everything except reset, but never disturbs an idle sequencer
      if (abort && state != IDLE) begin
         state_nxt = IDLE;
         i_nxt     = '0;
         n_nxt     = '0;
         w_nxt     = '0;
      end
   end
endmodule

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer: scoreboard bench for layer_sequencer at default parameters.
module tb_layer_sequencer;
   localparam int NONE = 1000;
   logic clk = 0, rst = 1, start = 0, abort = 0, mem_ready = 1;
   logic busy, done, clr_acc, en_mac, en_act, wr_out;
   logic [2:0] x_addr;
   logic [4:0] w_addr;
   logic [1:0] out_addr;
   logic [15:0] all_out;
   int checks = 0, errors = 0;
   int xq[$], wq[$], oq[$];
   int done_at, done_cnt, busy_cnt, clr_cnt, mac_cnt, wr_cnt;
   layer_sequencer dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .mem_ready(mem_ready),
      .busy(busy), .done(done), .clr_acc(clr_acc), .en_mac(en_mac), .en_act(en_act),
      .wr_out(wr_out), .x_addr(x_addr), .w_addr(w_addr), .out_addr(out_addr)
   );
   assign all_out = {busy, done, clr_acc, en_mac, en_act, wr_out, x_addr, w_addr, out_addr};
   always #5 clk = ~clk;
   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   task automatic push_pass();
      for (int n = 0; n < 4; n++) begin
         for (int i = 0; i < 8; i++) begin
            xq.push_back(i);
            wq.push_back(n*8 + i);
         end
         oq.push_back(n);
      end
   endtask
   // Cycle c is the c-th cycle after the edge that samples start.
   task automatic run_pass(input int max_c, input int stall_at, input int stall_len, input int abort_at,
                           input int pulse_at, input int rst_at, input int hold);
      done_at = 0; done_cnt = 0; busy_cnt = 0; clr_cnt = 0; mac_cnt = 0; wr_cnt = 0;
      push_pass();
      if (hold > 0) push_pass();
      start = 1;
      @(posedge clk); #1;
      for (int c = 1; c <= max_c; c++) begin
         start     = (c <= hold) || (c == pulse_at);
         abort     = (c == abort_at);
         rst       = (c == rst_at);
         mem_ready = !(c >= stall_at && c < stall_at + stall_len);
         if (c == abort_at + 1 || c == rst_at + 1) begin
            xq.delete(); wq.delete(); oq.delete();
         end
         @(negedge clk);
         if (c == abort_at + 1 || c == rst_at + 1) check("cancel_idle", int'(all_out), 0);
         if (!mem_ready) begin
            check("stall_en_mac", int'(en_mac), 0);
            check("stall_x", int'(x_addr), 5);
            check("stall_w", int'(w_addr), 21);
         end
         if (hold > 0 && c == hold) check("b2b_idle_busy", int'(busy), 0);
         if (hold > 0 && c == hold + 1) check("b2b_clr_w0", int'({clr_acc, w_addr}), 32);
         busy_cnt += int'(busy);
         clr_cnt  += int'(clr_acc);
         if (done) begin
            done_cnt++;
            if (done_at == 0) done_at = c;
         end
         if (en_mac) begin
            mac_cnt++;
            if (xq.size() == 0) check("mac_unexpected", 1, 0);
            else begin
               check("mac_x", int'(x_addr), xq.pop_front());
               check("mac_w", int'(w_addr), wq.pop_front());
            end
         end
         if (wr_out) begin
            wr_cnt++;
            if (oq.size() == 0) check("wr_unexpected", 1, 0);
            else check("wr_addr", int'(out_addr), oq.pop_front());
         end
         @(posedge clk); #1;
      end
      start = 0; abort = 0; rst = 0; mem_ready = 1;
   endtask
   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      check("reset_outputs", int'(all_out), 0);
      @(posedge clk); #1;
      run_pass(50, NONE, 0, NONE, NONE, NONE, 0);
      check("done_cycle", done_at, 45);
      check("busy_cycles", busy_cnt, 45);
      check("done_pulses", done_cnt, 1);
      check("clr_pulses", clr_cnt, 4);
      check("mac_cycles", mac_cnt, 32);
      check("writes", wr_cnt, 4);
      check("sb_empty", xq.size() + oq.size(), 0);
      run_pass(55, 29, 3, NONE, NONE, NONE, 0);
      check("stall_done_cycle", done_at, 48);
      check("stall_busy", busy_cnt, 48);
      check("stall_mac_cycles", mac_cnt, 32);
      check("stall_sb_empty", xq.size() + oq.size(), 0);
      run_pass(25, NONE, 0, 15, NONE, NONE, 0);
      check("abort_no_done", done_cnt, 0);
      check("abort_busy", busy_cnt, 15);
      check("abort_clr", clr_cnt, 2);
      check("abort_mac", mac_cnt, 11);
      check("abort_writes", wr_cnt, 1);
      run_pass(50, NONE, 0, NONE, NONE, NONE, 0);
      check("restart_done_cycle", done_at, 45);
      check("restart_sb_empty", xq.size() + oq.size(), 0);
      run_pass(50, NONE, 0, NONE, 4, NONE, 0);
      check("busy_start_done_cycle", done_at, 45);
      check("busy_start_done_pulses", done_cnt, 1);
      run_pass(50, NONE, 0, NONE, NONE, 44, 0);
      check("rst_no_done", done_cnt, 0);
      check("rst_writes", wr_cnt, 4);
      check("rst_busy", busy_cnt, 44);
      abort = 1;
      repeat (3) begin
         @(negedge clk);
         check("idle_abort", int'(all_out), 0);
         @(posedge clk); #1;
      end
      run_pass(50, NONE, 0, NONE, NONE, NONE, 0);
      check("start_abort_done_cycle", done_at, 45);
      check("start_abort_writes", wr_cnt, 4);
      run_pass(95, NONE, 0, NONE, NONE, NONE, 46);
      check("b2b_first_done", done_at, 45);
      check("b2b_done_pulses", done_cnt, 2);
      check("b2b_busy", busy_cnt, 90);
      check("b2b_mac", mac_cnt, 64);
      check("b2b_writes", wr_cnt, 8);
      check("b2b_sb_empty", xq.size() + oq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
